// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit AXI4-Lite bridge.
package lsu_pkg;

  // funct3 access-size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_DONE
  } lsu_state_t;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == SZ_B) || (size == SZ_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == SZ_H) || (size == SZ_HU);
  endfunction

  // Unused size codes fall through to the word rule.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    if (is_byte(size))      return 1'b0;
    else if (is_half(size)) return addr_lo[0];
    else                    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  // Store lane strobes and replicated write data
  always_comb begin
    st_strb_o = 4'b1111;
    st_data_o = st_data_i;
    if (is_byte(size_i)) begin
      st_strb_o = 4'b0001 << addr_lo_i;
      st_data_o = {4{st_data_i[7:0]}};
    end else if (is_half(size_i)) begin
      st_strb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      st_data_o = {2{st_data_i[15:0]}};
    end
  end

  // Load lane select and sign/zero extension
  always_comb begin
    sext    = ~size_i[2];
    ld_byte = ld_word_i[7:0];
    case (addr_lo_i)
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      2'd3:    ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    if (is_byte(size_i))
      ld_data_o = {{24{sext & ld_byte[7]}}, ld_byte};
    else if (is_half(size_i))
      ld_data_o = {{16{sext & ld_half[15]}}, ld_half};
    else
      ld_data_o = ld_word_i;
  end

endmodule

// File: rtl/axi_lite_lsu_bridge.sv
// Single-outstanding bridge from the core data-memory port to AXI4-Lite.
module axi_lite_lsu_bridge
  import lsu_pkg::*;
#(
  parameter logic [2:0] PROT        = 3'b000,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic        req_re_i,
  input  logic [2:0]  req_size_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        hold_o,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_any;
  logic        mis;
  logic        err_n;
  logic [31:0] ld_data;

  assign req_any = req_we_i | req_re_i;

  lsu_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .st_data_i (wdata_q),
    .ld_word_i (m_rdata),
    .st_strb_o (m_wstrb),
    .st_data_o (m_wdata),
    .ld_data_o (ld_data)
  );

  assign m_awaddr  = {addr_q[31:2], 2'b00};
  assign m_araddr  = {addr_q[31:2], 2'b00};
  assign m_awprot  = PROT;
  assign m_arprot  = PROT;
  // Each write channel valid drops the cycle after its own handshake.
  assign m_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_bready  = (state_q == ST_WB);
  assign m_arvalid = (state_q == ST_RA);
  assign m_rready  = (state_q == ST_RD);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = (state_q == ST_DONE) && err_q;
  assign rdata_o   = rdata_q;
  assign hold_o    = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                     ((state_q == ST_IDLE) && req_any);

  // Next-state and captured transaction fields
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    mis       = 1'b0;
    err_n     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          size_d    = req_size_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          mis       = ALIGN_CHECK && is_misaligned(req_addr_i[1:0], req_size_i);
          err_d     = mis;
          if (mis) begin
            state_d = ST_DONE;
            if (!req_we_i) rdata_d = '0;
          end else begin
            state_d = req_we_i ? ST_WR : ST_RA;
          end
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q  | (m_wvalid  & m_wready);
        if (aw_done_d && w_done_d) state_d = ST_WB;
      end
      ST_WB: begin
        if (m_bvalid) begin
          err_d   = err_q | (m_bresp != 2'b00);
          state_d = ST_DONE;
        end
      end
      ST_RA: begin
        if (m_arready) state_d = ST_RD;
      end
      ST_RD: begin
        if (m_rvalid) begin
          err_n   = err_q | (m_rresp != 2'b00);
          err_d   = err_n;
          rdata_d = err_n ? '0 : ld_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_lsu_bridge.sv
// Scoreboard bench for axi_lite_lsu_bridge with a simple AXI4-Lite slave.
module tb_axi_lite_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_we_i, req_re_i;
  logic [2:0]  req_size_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, hold_o;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  always #5 clk = ~clk;

  axi_lite_lsu_bridge #(.PROT(3'b000), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_we_i(req_we_i), .req_re_i(req_re_i), .req_size_i(req_size_i),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .hold_o(hold_o),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];

  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
  bit          r_hold_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ld(input logic [31:0] rd, input logic e);
    exp_t x;
    x.is_load = 1'b1; x.rdata = rd; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic push_st(input logic e);
    exp_t x;
    x.is_load = 1'b0; x.rdata = '0; x.err = e;
    exp_q.push_back(x);
  endtask

  // Slave: drives its outputs on the falling edge
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0;
        m_arready = 0; m_rvalid = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (m_awvalid) begin m_awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin m_awready = 0; aw_cnt = 0; end
        if (m_wvalid) begin m_wready = (w_cnt >= w_delay); w_cnt++; end
        else begin m_wready = 0; w_cnt = 0; end
        m_bvalid  = m_bready;
        m_bresp   = b_resp;
        m_arready = m_arvalid;
        m_rvalid  = m_rready && !r_hold_off;
        m_rdata   = r_data;
        m_rresp   = r_resp;
      end
    end
  end

  // Monitor: pops expectations on every handshake and completion
  initial begin
    exp_t e;
    logic [35:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (m_awvalid && m_awready) begin
          if (aw_q.size() == 0) begin
            total++; bad++;
            $display("FAIL aw_unexpected: got addr %h expected no AW", m_awaddr);
          end else chk("awaddr", m_awaddr, aw_q.pop_front());
        end
        if (m_wvalid && m_wready) begin
          if (w_q.size() == 0) begin
            total++; bad++;
            $display("FAIL w_unexpected: got data %h expected no W", m_wdata);
          end else begin
            w = w_q.pop_front();
            chk("wstrb", {28'd0, m_wstrb}, {28'd0, w[35:32]});
            chk("wdata", m_wdata, w[31:0]);
          end
        end
        if (m_arvalid && m_arready) begin
          if (ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_unexpected: got addr %h expected no AR", m_araddr);
          end else chk("araddr", m_araddr, ar_q.pop_front());
        end
        if (done_o) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got done_o=1 expected 0");
          end else begin
            e = exp_q.pop_front();
            if (e.is_load) chk("rdata", rdata_o, e.rdata);
            chk("err", {31'd0, err_o}, {31'd0, e.err});
          end
        end
      end
    end
  end

  // One request: drive for a single accept cycle, then wait for completion
  task automatic op(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                    input logic re, input logic [2:0] sz, input int exp_hold, input bit probe);
    int  hcnt;
    bit  got, pend;
    hcnt = 0; got = 0; pend = 0;
    @(negedge clk);
    req_addr_i = addr; req_wdata_i = wd; req_we_i = we; req_re_i = re; req_size_i = sz;
    #2;
    hcnt += int'(hold_o);
    @(posedge clk);
    @(negedge clk);
    req_we_i = 0; req_re_i = 0;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (pend) begin
        chk("awvalid_dropped", {31'd0, m_awvalid}, 32'd0);
        chk("wvalid_held", {31'd0, m_wvalid}, 32'd1);
        pend = 0;
      end
      if (probe && m_awvalid && m_awready) pend = 1;
      if (done_o) begin got = 1; break; end
      hcnt += int'(hold_o);
      @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done_o expected done_o within 60 cycles");
    end
    if (exp_hold >= 0) chk("hold_cycles", hcnt, exp_hold);
    @(negedge clk);
    #2;
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    rst = 1; req_addr_i = 0; req_wdata_i = 0; req_we_i = 0; req_re_i = 0; req_size_i = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_hold", {31'd0, hold_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, m_bready | m_rready}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("prot", {26'd0, m_awprot, m_arprot}, 32'd0);
    @(negedge clk);
    rst = 0;

    // LW aligned
    r_data = 32'hDEADBEEF; ar_q.push_back(32'h100); push_ld(32'hDEADBEEF, 0);
    op(32'h100, 0, 0, 1, 3'b010, 3, 0);
    // LB / LBU byte 3
    r_data = 32'h80112233;
    ar_q.push_back(32'h200); push_ld(32'hFFFFFF80, 0);
    op(32'h203, 0, 0, 1, 3'b000, 3, 0);
    ar_q.push_back(32'h200); push_ld(32'h00000080, 0);
    op(32'h203, 0, 0, 1, 3'b100, 3, 0);
    // LH / LHU upper half
    r_data = 32'h80017FFF;
    ar_q.push_back(32'h204); push_ld(32'hFFFF8001, 0);
    op(32'h206, 0, 0, 1, 3'b001, 3, 0);
    ar_q.push_back(32'h204); push_ld(32'h00008001, 0);
    op(32'h206, 0, 0, 1, 3'b101, 3, 0);
    // SH upper half
    aw_q.push_back(32'h300); w_q.push_back({4'b1100, 32'hABCDABCD}); push_st(0);
    op(32'h302, 32'h0000ABCD, 1, 0, 3'b001, 3, 0);
    // SB byte 1, with re also set (store wins)
    aw_q.push_back(32'h100); w_q.push_back({4'b0010, 32'h55555555}); push_st(0);
    op(32'h101, 32'h00000055, 1, 1, 3'b000, 3, 0);
    // SW with WREADY three cycles after AWREADY
    aw_delay = 0; w_delay = 3;
    aw_q.push_back(32'h400); w_q.push_back({4'b1111, 32'h12345678}); push_st(0);
    op(32'h400, 32'h12345678, 1, 0, 3'b010, -1, 1);
    w_delay = 0;
    // Misaligned LW and SH: no bus traffic, error next cycle
    push_ld(32'h0, 1);
    op(32'h102, 0, 0, 1, 3'b010, 1, 0);
    push_st(1);
    op(32'h301, 32'h1234, 1, 0, 3'b001, 1, 0);
    // Load with RRESP error
    r_resp = 2'b10; r_data = 32'h11112222;
    ar_q.push_back(32'h104); push_ld(32'h0, 1);
    op(32'h104, 0, 0, 1, 3'b010, 3, 0);
    r_resp = 2'b00;
    // Store with BRESP error
    b_resp = 2'b10;
    aw_q.push_back(32'h500); w_q.push_back({4'b1111, 32'hA5A5A5A5}); push_st(1);
    op(32'h500, 32'hA5A5A5A5, 1, 0, 3'b010, 3, 0);
    b_resp = 2'b00;

    // Reset while waiting in RD
    r_hold_off = 1; ar_q.push_back(32'h108);
    @(negedge clk);
    req_addr_i = 32'h108; req_we_i = 0; req_re_i = 1; req_size_i = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_re_i = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (m_rready) break;
      @(negedge clk);
    end
    chk("rready_before_rst", {31'd0, m_rready}, 32'd1);
    rst = 1;
    #1;
    chk("rst_rready", {31'd0, m_rready}, 32'd0);
    chk("rst_done_mid", {31'd0, done_o}, 32'd0);
    chk("rst_hold_mid", {31'd0, hold_o}, 32'd0);
    chk("rst_rdata_mid", rdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0; r_hold_off = 0;
    r_data = 32'hCAFEF00D; ar_q.push_back(32'h108); push_ld(32'hCAFEF00D, 0);
    op(32'h108, 0, 0, 1, 3'b010, 3, 0);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("aw_q_empty", aw_q.size(), 32'd0);
    chk("w_q_empty", w_q.size(), 32'd0);
    chk("ar_q_empty", ar_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_lsu_bridge.md
Name: axi_lite_lsu_bridge

Overview:
- Sequences the core's single-cycle data-memory request port (address, write data, we/re, size) onto the AXI4-Lite master channels.
- Holds the pipeline while a transaction is outstanding, then returns aligned, sign- or zero-extended load data.
- Sits between the EX-stage memory outputs and the top-level m_* AXI4-Lite pins; one transaction is in flight at a time.

Parameters:
- PROT, 3'b000, constant value driven on m_awprot and m_arprot.
- ALIGN_CHECK, 1, 1 = misaligned accesses complete with error and no bus traffic; 0 = address low bits are ignored for halfword/word accesses.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_addr_i  in  32  byte address from EX
- req_wdata_i  in  32  store data, right-justified
- req_we_i  in  1  store request
- req_re_i  in  1  load request
- req_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rdata_o  out  32  extended load data
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error qualifier, valid only with done_o
- hold_o  out  1  pipeline stall request
- m_awaddr/m_awprot/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready, m_araddr/m_arprot/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready  standard AXI4-Lite master, widths 32/3/1/1, 32/4/1/1, 2/1/1, 32/3/1/1, 32/2/1/1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset (may arrive mid-transaction): state goes to IDLE; all *valid, *ready, done_o and err_o go to 0; rdata_o goes to 0. Any outstanding bus transaction is abandoned.
- States: IDLE, WR (AW/W pending), WB (wait B), RA (AR pending), RD (wait R), DONE.
- Accepting a request in IDLE:
  - If req_we_i or req_re_i is set, capture addr, wdata and size, and set the error flag if misaligned.
  - req_we_i takes priority if both are set.
  - Misaligned (when ALIGN_CHECK=1) means H/HU with addr[0]=1, or W with addr[1:0]!=0. A misaligned request goes straight to DONE.
  - Otherwise a store goes to WR and a load goes to RA.
- hold_o = (state!=IDLE && state!=DONE) || (state==IDLE && (req_we_i||req_re_i)). It is combinational, so the pipeline freezes in the request cycle and advances on the DONE edge.
- Addresses: m_awaddr and m_araddr = {addr[31:2],2'b00}.
- Store strobe and data:
  - B: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - W: wstrb = 4'b1111, wdata unchanged.
- WR state:
  - AWVALID and WVALID rise together on entry.
  - Each drops independently in the cycle after its own valid&&ready.
  - Move to WB once both handshakes are seen; they may occur in the same cycle.
- WB state: BREADY=1. On BVALID, latch err |= (bresp!=0) and go to DONE.
- RA state: ARVALID=1 until ARREADY, then go to RD.
- RD state: RREADY=1. On RVALID:
  - rdata_o = extract(m_rdata, addr[1:0], size).
  - B/H select byte/halfword addr[1:0] / addr[1], then sign-extend; BU/HU zero-extend; W passes through.
  - err |= (rresp!=0); go to DONE.
- Errored loads: rdata_o = 0.
- DONE: done_o=1 and err_o=err for exactly 1 cycle, then IDLE. rdata_o is held until the next load completes.
- Valid signals never drop before their handshake, and no timeout exists.
- Latency with zero-wait slaves:
  - Load: request cycle, RA, RD, DONE = 3 cycles of hold.
  - Store: WR, WB, DONE.
- Unused size codes (011, 11x): treated as W.

Decomposition:
- lsu_pkg holds:
  - size localparams SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU
  - state enum lsu_state_t
  - function is_misaligned()
- Sub-module lsu_align (combinational) holds strobe/wdata replication and load extraction, so it can be reused by a future cache.

Test Plan:
- LW at 0x100, slave returns 0xDEADBEEF, zero-wait -> hold_o high for 3 cycles; done_o pulse; rdata_o=0xDEADBEEF; err_o=0; m_araddr=0x100.
- LB at 0x203, m_rdata=0x80112233 -> rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x302 with wdata 0x0000ABCD -> m_awaddr=0x300, m_wstrb=4'b1100, m_wdata=0xABCDABCD.
- SW where AWREADY comes 3 cycles before WREADY -> AWVALID drops after its handshake; WVALID holds until WREADY; single done_o only after BVALID.
- LW at 0x102 with ALIGN_CHECK=1 -> no ARVALID; done_o and err_o pulse the cycle after request. RRESP=2'b10 on an aligned load -> err_o=1, rdata_o=0.
- rst asserted during RD with RVALID low -> RREADY, done_o and hold_o drop immediately. A new LW after rst release completes normally.
